ir_trace_matcher: RTL and testbench
===================================

IR_TRACE_MATCHER -- requirements
Module: ir_trace_matcher

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive identical ir_in samples needed to accept a reading (10 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000000, maximum cycles allowed between successive correct steps (2 s).
REQ-003 Parameter TRACE_LEN, default 4, number of steps per trace, legal range 1-4.
REQ-004 clock  in  1  system clock; all state on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  gameplay active; low forces IDLE.
REQ-007 ir_in  in  16  raw IR receiver bits; 1 = beam detected at that sensor.
REQ-008 trace_target  in  16  four 4-bit sensor indices; step 0 in [3:0], step k in [4k+3:4k].
REQ-009 trace_load  in  1  one-cycle pulse that latches trace_target.
REQ-010 hit_valid  out  1  one-cycle pulse when a debounced single-sensor hit occurs.
REQ-011 hit_sensor  out  4  index of the sensor hit; valid with hit_valid.
REQ-012 step_idx  out  3  number of steps completed in the current attempt.
REQ-013 match_pulse  out  1  one-cycle pulse when the full trace is completed.
REQ-014 miss_pulse  out  1  one-cycle pulse when an attempt fails.
REQ-015 busy  out  1  high in TRACKING.

Function
REQ-016 Debounce: a counter restarts whenever ir_in differs from the prior sample; when it reaches DEBOUNCE_CYCLES-1, the sample becomes the stable value.
REQ-017 Hit event: the stable value changes to a value with exactly one bit set -> hit_valid=1 for one cycle, hit_sensor=encoded index; a zero or multi-bit value produces no event; a held value produces no repeat event.
REQ-018 Hit latency: hit_valid asserts 1 cycle after the stable value updates.
REQ-019 FSM states: IDLE, ARMED, TRACKING, DONE.
REQ-020 IDLE -> ARMED on enable & trace_load; the target is latched on that edge.
REQ-021 ARMED: a hit equal to step 0 -> TRACKING, step_idx=1, timer cleared; any other hit is ignored.
REQ-022 TRACKING: a hit equal to step[step_idx] -> step_idx+1 and timer cleared; if the new step_idx equals TRACE_LEN -> match_pulse and DONE.
REQ-023 TRACKING: a hit on any other sensor -> miss_pulse, ARMED, step_idx=0.
REQ-024 TRACKING: timer reaches TIMEOUT_CYCLES-1 with no correct hit -> miss_pulse, ARMED, step_idx=0.
REQ-025 Same-cycle correct hit and timeout: the hit wins; no miss_pulse.
REQ-026 DONE lasts one cycle, then ARMED with step_idx=0 (same target re-armed).
REQ-027 TRACE_LEN=1: the step-0 hit goes from ARMED directly to DONE with match_pulse.
REQ-028 trace_load in ARMED/TRACKING/DONE -> relatch the target, ARMED, step_idx=0, no miss_pulse.
REQ-029 enable low in any state -> IDLE next cycle; no match_pulse or miss_pulse; the debouncer keeps running.
REQ-030 match_pulse and miss_pulse are never high together; both are registered outputs.

Reset
REQ-031 reset -> IDLE; step_idx=0, hit_valid=0, hit_sensor=0, match_pulse=0, miss_pulse=0, busy=0.
REQ-032 reset also clears the stable value to 0, the debounce counter, the timer and the latched target; reset mid-trace discards the attempt without a pulse.

Configuration
REQ-033 Macro IR_TRACE_MISS_COUNT_EN defined -> adds output miss_count [7:0], incremented on each miss_pulse, saturating at 255, cleared by reset and by trace_load.
REQ-034 Macro absent -> no miss_count port or logic; all other behaviour identical.

Structure
REQ-035 Package ir_trace_pkg holds the state enum, SENSOR_IDX_W=4, MAX_TRACE_LEN=4, and a step-extraction function.
REQ-036 Sub-module ir_debounce (16-bit debounce and single-hot hit encoder, REQ-016 to REQ-018) is instantiated once.

Verification (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, TRACE_LEN=4)
REQ-037 Load target 0x3210, present sensors 0,1,2,3 each held 10 cycles -> hit_valid x4, step_idx 1..4, one match_pulse, DONE then ARMED.
REQ-038 ir_in toggles bit 5 every 2 cycles for 20 cycles -> no hit_valid; then 0x0003 held 10 cycles -> no hit_valid (multi-bit).
REQ-039 Target 0x3210, hits 0,1, then sensor 7 -> miss_pulse, step_idx=0; with the macro defined, miss_count=1.
REQ-040 Target 0x3210, hit 0 then idle 100 cycles -> miss_pulse on the timeout cycle; a correct hit landing on the timeout cycle -> step advances, no miss.
REQ-041 Mid-trace (step_idx=2): trace_load -> ARMED, no pulse; separately, enable=0 -> IDLE next cycle; separately, reset -> all outputs 0.
REQ-042 With the macro defined, 300 misses -> miss_count holds at 255.

Source files
------------

// File: rtl/ir_trace_pkg.sv
// Shared state encoding, sizing constants and step-extraction helper for the IR trace matcher.
package ir_trace_pkg;

    localparam int SENSOR_IDX_W  = 4;
    localparam int MAX_TRACE_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TRACKING,
        DONE
    } trace_state_e;

    // Step k occupies target bits [4k+3:4k].
    function automatic logic [SENSOR_IDX_W-1:0] get_step(
        input logic [SENSOR_IDX_W*MAX_TRACE_LEN-1:0] target,
        input logic [1:0]                            idx
    );
        return target[{idx, 2'b00} +: SENSOR_IDX_W];
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// 16-bit IR input debouncer with a single-hot hit encoder; a hit pulses one cycle after
// the stable value changes to a value with exactly one bit set.
module ir_debounce
    import ir_trace_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             ir_in,
    output logic                    hit_valid,
    output logic [SENSOR_IDX_W-1:0] hit_sensor
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [15:0]             sample_q;
    logic [15:0]             stable_q;
    logic [15:0]             stable_prev_q;
    logic [CW-1:0]           count_q;
    logic                    hit_valid_q;
    logic [SENSOR_IDX_W-1:0] hit_sensor_q;
    logic                    single_hot;
    logic [SENSOR_IDX_W-1:0] hot_idx;

    always_comb begin
        single_hot = (stable_q != 16'd0) && ((stable_q & (stable_q - 16'd1)) == 16'd0);
        hot_idx    = '0;
        for (int i = 0; i < 16; i++) begin
            if (stable_q[i]) begin
                hot_idx = SENSOR_IDX_W'(i);
            end
        end
    end

    // The counter saturates once the sample is accepted, so a held value is re-accepted harmlessly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
            stable_q <= '0;
            count_q  <= '0;
        end else begin
            sample_q <= ir_in;
            if (ir_in != sample_q) begin
                count_q <= '0;
            end else if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sample_q;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_prev_q <= '0;
            hit_valid_q   <= 1'b0;
            hit_sensor_q  <= '0;
        end else begin
            stable_prev_q <= stable_q;
            hit_valid_q   <= (stable_q != stable_prev_q) && single_hot;
            if ((stable_q != stable_prev_q) && single_hot) begin
                hit_sensor_q <= hot_idx;
            end
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_sensor = hit_sensor_q;

endmodule

// File: rtl/ir_trace_matcher.sv
// IR trace matcher: follows a latched sequence of sensor hits with a per-step timeout.
// Optional IR_TRACE_MISS_COUNT_EN adds a saturating miss_count output.
module ir_trace_matcher
    import ir_trace_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 100000000,
    parameter int TRACE_LEN       = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             ir_in,
    input  logic [15:0]             trace_target,
    input  logic                    trace_load,
    output logic                    hit_valid,
    output logic [SENSOR_IDX_W-1:0] hit_sensor,
    output logic [2:0]              step_idx,
    output logic                    match_pulse,
    output logic                    miss_pulse,
    output logic                    busy
`ifdef IR_TRACE_MISS_COUNT_EN
    ,
    output logic [7:0]              miss_count
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    trace_state_e   state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    target_q, target_d;
    logic           match_q, match_d;
    logic           miss_q, miss_d;
    logic           correct_hit;
    logic [2:0]     step_next;

    ir_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .ir_in      (ir_in),
        .hit_valid  (hit_valid),
        .hit_sensor (hit_sensor)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            timer_q  <= '0;
            target_q <= '0;
            match_q  <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            timer_q  <= timer_d;
            target_q <= target_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
        end
    end

    // ARMED is treated as "zero steps done", so one compare serves both ARMED and TRACKING.
    always_comb begin
        correct_hit = hit_valid && (hit_sensor == get_step(target_q, step_q[1:0]));
        step_next   = step_q + 3'd1;
        state_d     = state_q;
        step_d      = step_q;
        timer_d     = timer_q;
        target_d    = target_q;
        match_d     = 1'b0;
        miss_d      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            step_d  = '0;
            timer_d = '0;
        end else if (trace_load) begin
            target_d = trace_target;
            state_d  = ARMED;
            step_d   = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                ARMED, TRACKING: begin
                    if (correct_hit) begin
                        step_d  = step_next;
                        timer_d = '0;
                        if (step_next == 3'(TRACE_LEN)) begin
                            state_d = DONE;
                            match_d = 1'b1;
                        end else begin
                            state_d = TRACKING;
                        end
                    end else if (state_q == TRACKING) begin
                        if (hit_valid || (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                            state_d = ARMED;
                            step_d  = '0;
                            timer_d = '0;
                            miss_d  = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = ARMED;
                    step_d  = '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IR_TRACE_MISS_COUNT_EN
    logic [7:0] miss_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_count_q <= '0;
        end else if (trace_load) begin
            miss_count_q <= '0;
        end else if (miss_d && (miss_count_q != 8'hFF)) begin
            miss_count_q <= miss_count_q + 8'd1;
        end
    end

    assign miss_count = miss_count_q;
`endif

    assign step_idx    = step_q;
    assign match_pulse = match_q;
    assign miss_pulse  = miss_q;
    assign busy        = (state_q == TRACKING);

endmodule

// File: tb/tb_ir_trace_matcher.sv
// Directed self-checking bench for ir_trace_matcher (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, TRACE_LEN=4).
module tb_ir_trace_matcher;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] ir_in = '0;
    logic [15:0] trace_target = '0;
    logic        trace_load = 1'b0;
    logic        hit_valid;
    logic [3:0]  hit_sensor;
    logic [2:0]  step_idx;
    logic        match_pulse;
    logic        miss_pulse;
    logic        busy;
`ifdef IR_TRACE_MISS_COUNT_EN
    logic [7:0]  miss_count;
`endif

    int testsRun = 0;
    int failCount = 0;
    int hitCount = 0;
    int matchCount = 0;
    int missCount = 0;
    int bothHigh = 0;
    int lastHit = -1;
    int stepAtMatch = -1;
    int missSnap;
    int matchSnap;

    ir_trace_matcher #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100),
        .TRACE_LEN      (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .ir_in        (ir_in),
        .trace_target (trace_target),
        .trace_load   (trace_load),
        .hit_valid    (hit_valid),
        .hit_sensor   (hit_sensor),
        .step_idx     (step_idx),
        .match_pulse  (match_pulse),
        .miss_pulse   (miss_pulse),
        .busy         (busy)
`ifdef IR_TRACE_MISS_COUNT_EN
        ,
        .miss_count   (miss_count)
`endif
    );

    always #5 clock = ~clock;

    // Pulse bookkeeping, sampled mid-cycle where registered outputs are settled.
    always @(negedge clock) begin
        if (hit_valid) begin
            hitCount++;
            lastHit = int'(hit_sensor);
        end
        if (match_pulse) begin
            matchCount++;
            stepAtMatch = int'(step_idx);
        end
        if (miss_pulse) missCount++;
        if (match_pulse && miss_pulse) bothHigh++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int cycles);
        ir_in = value;
        repeat (cycles) nextCycle();
    endtask

    task automatic loadTarget(input logic [15:0] t);
        trace_target = t;
        trace_load   = 1'b1;
        nextCycle();
        trace_load   = 1'b0;
    endtask

    task automatic waitStep(input logic [2:0] expected, input string tag);
        for (int n = 0; n < 30; n++) begin
            if (step_idx == expected) break;
            nextCycle();
        end
        checkOutput(tag, 32'(step_idx), 32'(expected));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        nextCycle();
        checkOutput("rst_step", 32'(step_idx), 0);
        checkOutput("rst_hit_valid", 32'(hit_valid), 0);
        checkOutput("rst_hit_sensor", 32'(hit_sensor), 0);
        checkOutput("rst_match", 32'(match_pulse), 0);
        checkOutput("rst_miss", 32'(miss_pulse), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        nextCycle();

        // Full trace 0,1,2,3
        enable = 1'b1;
        loadTarget(16'h3210);
        applyStimulus(16'h0001, 10);
        checkOutput("trace_step1", 32'(step_idx), 1);
        checkOutput("trace_busy", 32'(busy), 1);
        applyStimulus(16'h0002, 10);
        applyStimulus(16'h0004, 10);
        checkOutput("trace_step3", 32'(step_idx), 3);
        applyStimulus(16'h0008, 10);
        checkOutput("trace_hits", 32'(hitCount), 4);
        checkOutput("trace_last_sensor", 32'(lastHit), 3);
        checkOutput("trace_matches", 32'(matchCount), 1);
        checkOutput("trace_step_at_match", 32'(stepAtMatch), 4);
        checkOutput("trace_rearmed_step", 32'(step_idx), 0);
        checkOutput("trace_rearmed_busy", 32'(busy), 0);
        applyStimulus(16'h0000, 10);

        // Bouncing input and multi-bit input produce no hits
        hitCount = 0;
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 16'h0020 : 16'h0000, 2);
        applyStimulus(16'h0000, 8);
        checkOutput("bounce_no_hit", 32'(hitCount), 0);
        applyStimulus(16'h0003, 10);
        applyStimulus(16'h0000, 10);
        checkOutput("multibit_no_hit", 32'(hitCount), 0);

        // Wrong sensor mid-trace
        missSnap = missCount;
        loadTarget(16'h3210);
        applyStimulus(16'h0001, 10);
        applyStimulus(16'h0002, 10);
        checkOutput("wrong_pre_step", 32'(step_idx), 2);
        applyStimulus(16'h0080, 10);
        checkOutput("wrong_miss", 32'(missCount - missSnap), 1);
        checkOutput("wrong_sensor", 32'(lastHit), 7);
        checkOutput("wrong_step", 32'(step_idx), 0);
        checkOutput("wrong_busy", 32'(busy), 0);
`ifdef IR_TRACE_MISS_COUNT_EN
        checkOutput("wrong_miss_count", 32'(miss_count), 1);
`endif
        applyStimulus(16'h0000, 10);

        // Timeout after step 0
        loadTarget(16'h3210);
        ir_in = 16'h0001;
        waitStep(3'd1, "to_enter");
        ir_in = 16'h0000;
        for (int k = 1; k <= 100; k++) begin
            nextCycle();
            if (k == 99) begin
                checkOutput("to_before_miss", 32'(miss_pulse), 0);
                checkOutput("to_before_step", 32'(step_idx), 1);
            end
        end
        checkOutput("to_miss", 32'(miss_pulse), 1);
        checkOutput("to_step", 32'(step_idx), 0);
        checkOutput("to_busy", 32'(busy), 0);
`ifdef IR_TRACE_MISS_COUNT_EN
        checkOutput("to_miss_count", 32'(miss_count), 1);
`endif
        applyStimulus(16'h0000, 10);

        // Correct hit on the timeout cycle wins
        missSnap = missCount;
        ir_in = 16'h0001;
        waitStep(3'd1, "race_enter");
        ir_in = 16'h0000;
        for (int k = 1; k <= 100; k++) begin
            nextCycle();
            if (k == 93) ir_in = 16'h0002;
            if (k == 99) begin
                checkOutput("race_hit_valid", 32'(hit_valid), 1);
                checkOutput("race_hit_sensor", 32'(hit_sensor), 1);
                checkOutput("race_step_before", 32'(step_idx), 1);
            end
        end
        checkOutput("race_step", 32'(step_idx), 2);
        checkOutput("race_no_miss", 32'(miss_pulse), 0);
        checkOutput("race_busy", 32'(busy), 1);

        // Reload mid-trace relatches the target without a pulse
        missSnap  = missCount;
        matchSnap = matchCount;
        loadTarget(16'h3215);
        checkOutput("reload_step", 32'(step_idx), 0);
        checkOutput("reload_busy", 32'(busy), 0);
        applyStimulus(16'h0020, 10);
        checkOutput("reload_new_step0", 32'(step_idx), 1);
        applyStimulus(16'h0002, 10);
        checkOutput("reload_new_step1", 32'(step_idx), 2);
        checkOutput("reload_no_miss", 32'(missCount - missSnap), 0);

        // Enable low mid-trace forces IDLE
        enable = 1'b0;
        nextCycle();
        checkOutput("dis_step", 32'(step_idx), 0);
        checkOutput("dis_busy", 32'(busy), 0);
        enable = 1'b1;
        applyStimulus(16'h0020, 10);
        checkOutput("dis_idle_ignores_hit", 32'(step_idx), 0);
        checkOutput("dis_no_pulses", 32'((missCount - missSnap) + (matchCount - matchSnap)), 0);
        applyStimulus(16'h0000, 10);

        // Reset mid-trace
        loadTarget(16'h3210);
        applyStimulus(16'h0001, 10);
        applyStimulus(16'h0002, 10);
        checkOutput("mid_rst_pre_step", 32'(step_idx), 2);
        missSnap = missCount;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_step", 32'(step_idx), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_hit_sensor", 32'(hit_sensor), 0);
`ifdef IR_TRACE_MISS_COUNT_EN
        checkOutput("mid_rst_miss_count", 32'(miss_count), 0);
`endif
        ir_in = 16'h0000;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        nextCycle();
        checkOutput("mid_rst_no_miss", 32'(missCount - missSnap), 0);

`ifdef IR_TRACE_MISS_COUNT_EN
        // Saturation of the miss counter
        missSnap = missCount;
        loadTarget(16'h3210);
        checkOutput("sat_cleared", 32'(miss_count), 0);
        for (int m = 0; m < 300; m++) begin
            applyStimulus(16'h0001, 8);
            applyStimulus(16'h0080, 8);
        end
        checkOutput("sat_misses", 32'(missCount - missSnap), 300);
        checkOutput("sat_count", 32'(miss_count), 255);
`endif

        checkOutput("pulses_exclusive", 32'(bothHigh), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
